// File: rtl/lcd_scan_n.sv
// lcd_scan_n: multiplexed seven-segment display driver.
// Scans DIGITS digits one slot at a time with dead-time blanking, a 16-level
// brightness PWM, per-digit decimal points and optional leading-zero blanking.
// All display inputs are snapshotted once per frame so a frame never tears.

module lcd_scan_n #(
    parameter int DIGITS           = 4,
    parameter int DIV              = 1024,
    parameter int BLANK            = 8,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   i_digits,
    input  logic [DIGITS-1:0]     i_show,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [3:0]            i_brightness,
    input  logic                  i_lzb,
    output logic [DIGITS-1:0]     o_select,
    output logic [7:0]            o_segment,
    output logic                  o_frame
);

    // Counter and arithmetic widths. The on-window product needs four extra
    // bits for the brightness multiplier plus one for the exact DIV*16 case.
    localparam int TW = $clog2(DIV);
    localparam int SW = $clog2(DIGITS);
    localparam int OW = TW + 5;

    localparam logic [TW-1:0]     T_LAST  = TW'(DIV - 1);
    localparam logic [SW-1:0]     S_LAST  = SW'(DIGITS - 1);
    localparam logic [OW-1:0]     SPAN    = OW'(DIV - BLANK);
    localparam logic [OW-1:0]     BLANK_W = OW'(BLANK);
    localparam logic [DIGITS-1:0] SEL_OFF = ANODE_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    // Scan position: tick within the slot and the slot (digit) index.
    logic [TW-1:0] t;
    logic [SW-1:0] s;

    // Per-frame snapshot of every display input.
    logic [4*DIGITS-1:0] sh_digits;
    logic [DIGITS-1:0]   sh_show;
    logic [DIGITS-1:0]   sh_dp;
    logic [3:0]          sh_brightness;
    logic                sh_lzb;

    // Derived display state for the current slot.
    logic              last_tick;
    logic              capture;
    logic [DIGITS-1:0] lzb_blank;
    logic [DIGITS-1:0] visible;
    logic [3:0]        cur_value;
    logic              cur_dp;
    logic              cur_visible;
    logic [OW-1:0]     on_len;
    logic [OW-1:0]     t_wide;
    logic              in_window;
    logic              lit;
    logic [DIGITS-1:0] sel_next;
    logic [7:0]        seg_next;

    // Active-high hex glyphs in {G,F,E,D,C,B,A} order.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign last_tick = (t == T_LAST);
    assign capture   = last_tick && (s == S_LAST);

    // Advance the tick every cycle and the slot index whenever a slot completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t <= '0;
            s <= '0;
        end else if (last_tick) begin
            t <= '0;
            s <= (s == S_LAST) ? '0 : s + SW'(1);
        end else begin
            t <= t + TW'(1);
        end
    end

    // Snapshot all display inputs on the last cycle of the frame only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_digits     <= '0;
            sh_show       <= '0;
            sh_dp         <= '0;
            sh_brightness <= '0;
            sh_lzb        <= 1'b0;
        end else if (capture) begin
            sh_digits     <= i_digits;
            sh_show       <= i_show;
            sh_dp         <= i_dp;
            sh_brightness <= i_brightness;
            sh_lzb        <= i_lzb;
        end
    end

    // Walk from the most significant digit down, blanking zeros while every
    // digit above is zero or hidden; digit 0 always survives.
    always_comb begin : lzb_scan
        logic clear_above;
        clear_above = 1'b1;
        lzb_blank   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lzb_blank[k] = sh_lzb && clear_above && (sh_digits[4*k +: 4] == 4'h0);
            clear_above  = clear_above && ((sh_digits[4*k +: 4] == 4'h0) || !sh_show[k]);
        end
    end

    assign visible = sh_show & ~lzb_blank;

    // Select the value, decimal point and visibility of the digit being scanned.
    always_comb begin
        cur_value   = '0;
        cur_dp      = 1'b0;
        cur_visible = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (s == SW'(k)) begin
                cur_value   = sh_digits[4*k +: 4];
                cur_dp      = sh_dp[k];
                cur_visible = visible[k];
            end
        end
    end

    // PWM window: ON cycles starting right after the dead time.
    always_comb begin
        on_len    = (SPAN * ({{(OW-4){1'b0}}, sh_brightness} + OW'(1))) >> 4;
        t_wide    = {{(OW-TW){1'b0}}, t};
        in_window = (t_wide >= BLANK_W) && (t_wide < (BLANK_W + on_len));
        lit       = cur_visible && in_window;
    end

    // Active-high anode and segment patterns before polarity is applied.
    always_comb begin
        sel_next = '0;
        seg_next = 8'h00;
        if (lit) begin
            sel_next = DIGITS'(1) << s;
            seg_next = {cur_dp, hex7(cur_value)};
        end
    end

    // Register outputs together so anode and segments always switch on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_select  <= SEL_OFF;
            o_segment <= SEG_OFF;
            o_frame   <= 1'b0;
        end else begin
            o_select  <= sel_next ^ SEL_OFF;
            o_segment <= seg_next ^ SEG_OFF;
            o_frame   <= (s == '0) && (t == '0);
        end
    end

endmodule

// File: tb/tb_lcd_scan_n.sv
// tb_lcd_scan_n: directed self-checking bench for lcd_scan_n
// (DIGITS=4, DIV=32, BLANK=2, active-low anodes and segments).

module tb_lcd_scan_n;

    localparam int DIGITS = 4;
    localparam int DIV    = 32;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_digits;
    logic [3:0]  i_show;
    logic [3:0]  i_dp;
    logic [3:0]  i_brightness;
    logic        i_lzb;
    logic [3:0]  o_select;
    logic [7:0]  o_segment;
    logic        o_frame;

    int checks = 0;
    int errors = 0;

    logic [3:0] sel_log   [FRAME];
    logic [7:0] seg_log   [FRAME];
    logic       frame_log [FRAME];

    always #5 clk = ~clk;

    lcd_scan_n #(
        .DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .i_digits(i_digits), .i_show(i_show), .i_dp(i_dp),
        .i_brightness(i_brightness), .i_lzb(i_lzb),
        .o_select(o_select), .o_segment(o_segment), .o_frame(o_frame)
    );

    task automatic apply_inputs(input logic [15:0] d, input logic [3:0] sh,
                                input logic [3:0] dp, input logic [3:0] br, input logic lz);
        i_digits     = d;
        i_show       = sh;
        i_dp         = dp;
        i_brightness = br;
        i_lzb        = lz;
    endtask

    // Record one full frame of outputs, one sample per negedge.
    task automatic capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            sel_log[i]   = o_select;
            seg_log[i]   = o_segment;
            frame_log[i] = o_frame;
        end
    endtask

    task automatic test_reset();
        int s, t;
        logic [15:0] d;
        logic lit;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        d = 16'h1234;
        rst = 1'b0;
        apply_inputs(d, 4'hF, 4'h0, 4'd15, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (o_select !== 4'hF || o_segment !== 8'hFF || o_frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold sel=%h seg=%h frame=%b expected F FF 0", o_select, o_segment, o_frame);
        end
        rst = 1'b1;
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (sel_log[i] !== 4'hF || seg_log[i] !== 8'hFF || frame_log[i] !== (i == 0)) begin
                errors++;
                $display("[TB] FAIL reset_dark_frame i=%0d sel=%h seg=%h frame=%b expected F FF %0d",
                         i, sel_log[i], seg_log[i], frame_log[i], (i == 0));
            end
        end
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            s = i / DIV;
            t = i % DIV;
            lit = (t >= 2);
            exp_sel = lit ? ~(4'b0001 << s) : 4'hF;
            exp_seg = lit ? ~{1'b0, GLYPH[d[s*4 +: 4]]} : 8'hFF;
            checks++;
            if (sel_log[i] !== exp_sel || seg_log[i] !== exp_seg || frame_log[i] !== (i == 0)) begin
                errors++;
                $display("[TB] FAIL reset_first_frame i=%0d sel=%h seg=%h frame=%b expected %h %h %0d",
                         i, sel_log[i], seg_log[i], frame_log[i], exp_sel, exp_seg, (i == 0));
            end
        end
        checks++;
        if (sel_log[2] !== 4'b1110 || seg_log[2] !== ~8'h66) begin
            errors++;
            $display("[TB] FAIL reset_digit0_glyph sel=%b seg=%h expected 1110 99", sel_log[2], seg_log[2]);
        end
        checks++;
        if (sel_log[98] !== 4'b0111 || seg_log[98] !== ~8'h06) begin
            errors++;
            $display("[TB] FAIL reset_digit3_glyph sel=%b seg=%h expected 0111 f9", sel_log[98], seg_log[98]);
        end
    endtask

    task automatic test_brightness();
        int s, t, last_t;
        logic [3:0] level;
        logic [15:0] d;
        logic lit;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        d = 16'h1234;
        for (int v = 0; v < 2; v++) begin
            level  = (v == 0) ? 4'd7 : 4'd0;
            last_t = (v == 0) ? 16 : 2;
            apply_inputs(d, 4'hF, 4'h0, level, 1'b0);
            capture_frame();
            capture_frame();
            for (int i = 0; i < FRAME; i++) begin
                s = i / DIV;
                t = i % DIV;
                lit = (t >= 2) && (t <= last_t);
                exp_sel = lit ? ~(4'b0001 << s) : 4'hF;
                exp_seg = lit ? ~{1'b0, GLYPH[d[s*4 +: 4]]} : 8'hFF;
                checks++;
                if (sel_log[i] !== exp_sel || seg_log[i] !== exp_seg) begin
                    errors++;
                    $display("[TB] FAIL brightness_%0d i=%0d sel=%h seg=%h expected %h %h",
                             level, i, sel_log[i], seg_log[i], exp_sel, exp_seg);
                end
            end
        end
    endtask

    task automatic test_lzb();
        int s, t;
        logic [15:0] d;
        logic [3:0] show, vis;
        logic lit;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        for (int v = 0; v < 3; v++) begin
            case (v)
                0:       begin d = 16'h0050; show = 4'b1111; vis = 4'b0011; end
                1:       begin d = 16'h0000; show = 4'b1111; vis = 4'b0001; end
                default: begin d = 16'h5000; show = 4'b0111; vis = 4'b0001; end
            endcase
            apply_inputs(d, show, 4'b0110, 4'd15, 1'b1);
            if (v == 0) i_dp = 4'h0;
            capture_frame();
            capture_frame();
            for (int i = 0; i < FRAME; i++) begin
                s = i / DIV;
                t = i % DIV;
                lit = vis[s] && (t >= 2);
                exp_sel = lit ? ~(4'b0001 << s) : 4'hF;
                exp_seg = lit ? ~{i_dp[s], GLYPH[d[s*4 +: 4]]} : 8'hFF;
                checks++;
                if (sel_log[i] !== exp_sel || seg_log[i] !== exp_seg) begin
                    errors++;
                    $display("[TB] FAIL lzb_%h i=%0d sel=%h seg=%h expected %h %h",
                             d, i, sel_log[i], seg_log[i], exp_sel, exp_seg);
                end
            end
        end
    endtask

    task automatic test_dp_hide();
        int s, t;
        logic [15:0] d;
        logic [3:0] show, dp;
        logic lit;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        d = 16'h1234;
        for (int v = 0; v < 2; v++) begin
            show = (v == 0) ? 4'b1011 : 4'b1111;
            dp   = (v == 0) ? 4'b0100 : 4'b0001;
            apply_inputs(d, show, dp, 4'd15, 1'b0);
            capture_frame();
            capture_frame();
            for (int i = 0; i < FRAME; i++) begin
                s = i / DIV;
                t = i % DIV;
                lit = show[s] && (t >= 2);
                exp_sel = lit ? ~(4'b0001 << s) : 4'hF;
                exp_seg = lit ? ~{dp[s], GLYPH[d[s*4 +: 4]]} : 8'hFF;
                checks++;
                if (sel_log[i] !== exp_sel || seg_log[i] !== exp_seg) begin
                    errors++;
                    $display("[TB] FAIL dp_hide_%0d i=%0d sel=%h seg=%h expected %h %h",
                             v, i, sel_log[i], seg_log[i], exp_sel, exp_seg);
                end
            end
        end
        checks++;
        if (seg_log[2] !== ~8'hE6) begin
            errors++;
            $display("[TB] FAIL dp_digit0 seg=%h expected 19", seg_log[2]);
        end
    endtask

    task automatic test_tearing();
        int s, t;
        logic [3:0] val;
        logic lit;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        apply_inputs(16'h1111, 4'hF, 4'h0, 4'd15, 1'b0);
        capture_frame();
        capture_frame();
        for (int f = 0; f < 3; f++) begin
            val = 4'(f + 1);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                sel_log[i]   = o_select;
                seg_log[i]   = o_segment;
                frame_log[i] = o_frame;
                if (f == 0 && i == 50)  i_digits = 16'h2222;
                if (f == 1 && i == 126) i_digits = 16'h3333;
            end
            for (int i = 0; i < FRAME; i++) begin
                s = i / DIV;
                t = i % DIV;
                lit = (t >= 2);
                exp_sel = lit ? ~(4'b0001 << s) : 4'hF;
                exp_seg = lit ? ~{1'b0, GLYPH[val]} : 8'hFF;
                checks++;
                if (sel_log[i] !== exp_sel || seg_log[i] !== exp_seg || frame_log[i] !== (i == 0)) begin
                    errors++;
                    $display("[TB] FAIL tearing_frame%0d i=%0d sel=%h seg=%h frame=%b expected %h %h %0d",
                             f, i, sel_log[i], seg_log[i], frame_log[i], exp_sel, exp_seg, (i == 0));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int s, t;
        logic lit;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        // Display is showing "3333" at full brightness from the previous task.
        for (int i = 0; i <= 40; i++) @(negedge clk);
        checks++;
        if (o_select !== 4'b1101 || o_segment !== ~8'h4F) begin
            errors++;
            $display("[TB] FAIL async_pre_lit sel=%b seg=%h expected 1101 b0", o_select, o_segment);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (o_select !== 4'hF || o_segment !== 8'hFF || o_frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_immediate sel=%h seg=%h frame=%b expected F FF 0", o_select, o_segment, o_frame);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (sel_log[i] !== 4'hF || seg_log[i] !== 8'hFF || frame_log[i] !== (i == 0)) begin
                errors++;
                $display("[TB] FAIL async_dark_frame i=%0d sel=%h seg=%h frame=%b expected F FF %0d",
                         i, sel_log[i], seg_log[i], frame_log[i], (i == 0));
            end
        end
        capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            s = i / DIV;
            t = i % DIV;
            lit = (t >= 2);
            exp_sel = lit ? ~(4'b0001 << s) : 4'hF;
            exp_seg = lit ? ~{1'b0, GLYPH[3]} : 8'hFF;
            checks++;
            if (sel_log[i] !== exp_sel || seg_log[i] !== exp_seg || frame_log[i] !== (i == 0)) begin
                errors++;
                $display("[TB] FAIL async_restart i=%0d sel=%h seg=%h frame=%b expected %h %h %0d",
                         i, sel_log[i], seg_log[i], frame_log[i], exp_sel, exp_seg, (i == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_brightness();
        test_lzb();
        test_dp_hide();
        test_tearing();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule
